// File: rtl/irrigation_display_scan_pkg.sv
// Shared irrigation display types: zone mode codes and 7-segment glyphs (bit 6 = g .. bit 0 = a).
package irrigation_pkg;

    typedef enum logic [1:0] {
        MODE_NONE      = 2'b00,
        MODE_SPRINKLER = 2'b01,
        MODE_DRIP      = 2'b10,
        MODE_UNAUTH    = 2'b11
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_G     = 7'b0111101;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

endpackage

// File: rtl/irrigation_display_scan_if.sv
// Display bus between the irrigation control side (master) and the scan driver (slave).
interface irrigation_display_scan_if #(
    parameter int N_ZONES = 4
) ();
    logic                   en;
    logic [2*N_ZONES-1:0]   mode_bus;
    logic [6:0]             seg;
    logic [N_ZONES-1:0]     dig_n;
    logic                   frame_tick;

    modport master (output en, mode_bus, input seg, dig_n, frame_tick);
    modport slave  (input en, mode_bus, output seg, dig_n, frame_tick);
endinterface

// File: rtl/irrigation_display_scan_seg_lut.sv
// Combinational mode code to 7-segment pattern lookup, shared by the display blocks.
module irrigation_seg_lut
    import irrigation_pkg::*;
(
    input  mode_e       i_code,
    output logic [6:0]  o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            MODE_NONE:      o_seg = SEG_BLANK;
            MODE_SPRINKLER: o_seg = SEG_A;
            MODE_DRIP:      o_seg = SEG_G;
            MODE_UNAUTH:    o_seg = SEG_DASH;
            default:        o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/irrigation_display_scan.sv
// Multi-zone time-multiplexed 7-segment driver with dead time and frame pulse.
// Optional macro BLINK_UNAUTH_EN blinks code-11 digits every BLINK_DIV frames.
module irrigation_display_scan
    import irrigation_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25
) (
    input  logic                        clk,
    input  logic                        reset,
    irrigation_display_scan_if.slave    bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_ZONES - 1);

    if (N_ZONES < 1 || N_ZONES > 8 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
        $error("irrigation_display_scan: illegal parameter set");
    end

    logic [PW-1:0]      r_presc, w_presc_nx;
    logic [IW-1:0]      r_idx, w_idx_nx;
    mode_e              r_code, w_code_nx, w_code_lut;
    logic               r_first;
    logic               w_slot_end, w_wrap, w_dead;
    logic [6:0]         w_seg, r_seg;
    logic [N_ZONES-1:0] w_dig_n, r_dig_n;
    logic               r_frame_tick;

    // Outputs are computed from next state so they line up with the prescaler/index registers.
    always_comb begin
        w_slot_end = (r_presc == P_LAST);
        w_wrap     = w_slot_end && (r_idx == I_LAST);
        w_presc_nx = w_slot_end ? '0 : r_presc + 1'b1;
        w_idx_nx   = r_idx;
        if (w_slot_end)
            w_idx_nx = (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
        w_code_nx = r_code;
        if (w_slot_end || r_first) begin
            for (int k = 0; k < N_ZONES; k++)
                if (w_idx_nx == IW'(k))
                    w_code_nx = mode_e'(bus.mode_bus[2*k +: 2]);
        end
        w_dead  = (w_presc_nx == P_LAST);
        w_dig_n = '1;
        if (!w_dead) begin
            for (int k = 0; k < N_ZONES; k++)
                if (w_idx_nx == IW'(k))
                    w_dig_n[k] = 1'b0;
        end
    end

`ifdef BLINK_UNAUTH_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0]  r_bcnt;
    logic           r_phase, w_phase_nx;

    // Phase 1 = visible; flipping on the frame-wrap edge lets the new frame use the new phase.
    always_comb begin
        w_phase_nx = r_phase;
        if (w_wrap && (r_bcnt == BW'(BLINK_DIV - 1)))
            w_phase_nx = ~r_phase;
        w_code_lut = (!w_phase_nx && (w_code_nx == MODE_UNAUTH)) ? MODE_NONE : w_code_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (bus.en && w_wrap) begin
            r_bcnt  <= (r_bcnt == BW'(BLINK_DIV - 1)) ? '0 : r_bcnt + 1'b1;
            r_phase <= w_phase_nx;
        end
    end
`else
    always_comb w_code_lut = w_code_nx;
`endif

    irrigation_seg_lut u_lut (.i_code(w_code_lut), .o_seg(w_seg));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_code       <= MODE_NONE;
            r_first      <= 1'b1;
            r_seg        <= SEG_BLANK;
            r_dig_n      <= '1;
            r_frame_tick <= 1'b0;
        end else if (bus.en) begin
            r_presc      <= w_presc_nx;
            r_idx        <= w_idx_nx;
            r_code       <= w_code_nx;
            r_first      <= 1'b0;
            r_seg        <= w_dead ? SEG_BLANK : w_seg;
            r_dig_n      <= w_dig_n;
            r_frame_tick <= w_wrap;
        end else begin
            r_seg        <= SEG_BLANK;
            r_dig_n      <= '1;
            r_frame_tick <= 1'b0;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dig_n      = r_dig_n;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: doc/irrigation_display_scan.md
Name: irrigation_display_scan

Overview:
- Multi-zone status display driver for the irrigation controller.
- Takes a 2-bit irrigation mode code per zone and time-multiplexes the zones onto one shared active-high 7-segment bus, with one active-low digit enable per zone.
- Successor to the single-digit combinational mode decoder: parametrised zone count, scan prescaler, registered glitch-free outputs, anti-ghost dead time and frame pulse.
- Sits between the irrigation control FSM outputs and the board display pins.

Parameters:
- N_ZONES, 4, number of zones/digits; legal range 1..8.
- SCAN_DIV, 50000, clk cycles per digit slot; must be >= 2.
- BLINK_DIV, 25, full scan frames per blink half-period; must be >= 1 (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  display enable; 0 blanks the display.
- mode_bus  in  2*N_ZONES  zone k code at bits [2k+1:2k].
- seg  out  7  segments, active-high; seg[0]=a .. seg[6]=g.
- dig_n  out  N_ZONES  digit enables, active-low; bit k = zone k.
- frame_tick  out  1  one-cycle pulse at the start of each full scan frame.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: seg=0, dig_n=all 1, frame_tick=0, prescaler=0, zone index=0, blink phase=visible, blink frame counter=0.
- Code map (seg[6:0], i.e. g..a):
  - 00 none -> 0000000 (blank).
  - 01 sprinkler -> 1110111 ("A").
  - 10 drip -> 0111101 ("G").
  - 11 unauthorised -> 1000000 ("-").
- Prescaler: counts 0..SCAN_DIV-1 and wraps. The terminal count (SCAN_DIV-1) produces slot_end.
- Zone index: advances on slot_end and wraps N_ZONES-1 -> 0. With N_ZONES=1 it stays at 0.
- Input sampling: the zone code is sampled from mode_bus only on the edge where the new slot starts (slot_end, and the first cycle after reset release). Changes mid-slot are displayed on the next visit to that zone.
- Output latency: seg and dig_n are registered, valid 1 cycle after the slot starts.
- dig_n during a slot: exactly one bit low, the bit for the current index.
- Dead time: when the prescaler equals SCAN_DIV-1, dig_n is all 1 and seg is 0 (1-cycle anti-ghosting gap per slot).
- frame_tick: 1 for exactly the cycle in which the index registers the wrap to 0. With N_ZONES=1 this occurs every slot.
- en=0: prescaler and index hold their values; from the next cycle seg=0, dig_n=all 1, frame_tick=0. On en returning to 1, scanning resumes from the held state with no skipped slot.
- Reset mid-slot: all state returns to reset values on the next edge. Reset has priority over en.
- Simultaneous slot_end and a mode_bus change: the value present on that edge is the one sampled.

Optional Feature:
- Macro BLINK_UNAUTH_EN.
- Defined: a frame counter counts frame_tick pulses 0..BLINK_DIV-1; at the wrap, the blink phase toggles. While the phase is off, code 11 digits show blank; other codes are unaffected. The counter holds while en=0.
- Not defined: no frame counter or blink phase register is built, and code 11 always shows "-".

Decomposition:
- Package irrigation_pkg holds:
  - 2-bit mode typedef/enum: MODE_NONE, MODE_SPRINKLER, MODE_DRIP, MODE_UNAUTH.
  - Segment constants: SEG_BLANK, SEG_A, SEG_G, SEG_DASH.
- One sub-module, irrigation_seg_lut: combinational code -> 7-bit pattern lookup. It is shared with other display blocks and instantiated once, after the index mux.

Test Plan:
- Reset then scan, with N_ZONES=4, SCAN_DIV=4, mode_bus=8'b11_10_01_00:
  - dig_n cycles through 1110 -> 1101 -> 1011 -> 0111, 3 cycles each, separated by a 1111 dead cycle.
  - seg shows 0000000, 1110111, 0111101, 1000000 in that order.
  - frame_tick pulses once every 16 cycles.
- Mid-slot change: while zone 1 is displayed, change code 01 -> 10. Zone 1 still shows 1110111 for the rest of the slot and shows 0111101 on the next frame.
- Enable gating: drop en for 10 cycles during zone 2's slot. seg=0 and dig_n=1111 throughout; scanning then resumes in zone 2 with the remaining slot count unchanged.
- Reset mid-scan: assert reset for 1 cycle during zone 3. Next cycle seg=0, dig_n=1111, index=0, and the first frame_tick occurs after the full 16-cycle frame.
- Edge configuration N_ZONES=1, SCAN_DIV=2: dig_n alternates 0,1, and frame_tick pulses every 2 cycles.
- Blink with BLINK_UNAUTH_EN defined, BLINK_DIV=2, all zones coded 11: digits show 1000000 for 2 frames, then 0000000 for 2 frames, repeating.
